// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared parameters and FSM state type for the binary fully-connected engine
package fc_pkg;
    localparam int N_CLASSES = 10;
    localparam int N_CHUNKS  = 60;
    localparam int CHUNK_W   = 16;
    localparam int SCORE_W   = 11;
    localparam int OFFSET_W  = 9;
    localparam int IN_W      = N_CHUNKS * CHUNK_W;
    localparam int W_BITS    = N_CLASSES * IN_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } fc_state_e;
endpackage

// File: rtl/fc_engine_if.sv
// rtl/fc_engine_if.sv - start/done handshake, operand arrays and results of the FC engine
interface fc_engine_if;
    import fc_pkg::*;

    logic                begin_fc;
    logic                done_fc;
    logic                in_fmap [0:IN_W-1];
    logic                weights [0:W_BITS-1];
    logic [OFFSET_W-1:0] offset  [0:N_CLASSES-1];
    logic [3:0]          class_out;
    logic [SCORE_W-1:0]  scores  [0:N_CLASSES-1];

    modport master (
        output begin_fc, in_fmap, weights, offset,
        input  done_fc, class_out, scores
    );

    modport slave (
        input  begin_fc, in_fmap, weights, offset,
        output done_fc, class_out, scores
    );
endinterface

// File: rtl/xnor_popcount16.sv
// rtl/xnor_popcount16.sv - number of equal bit positions between two 16-bit words
module xnor_popcount16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [4:0]  cnt_o
);
    logic [15:0] eq;

    always_comb begin
        eq    = ~(a_i ^ b_i);
        cnt_o = 5'd0;
        for (int b = 0; b < 16; b++) begin
            cnt_o = cnt_o + {4'd0, eq[b]};
        end
    end
endmodule

// File: rtl/fc_engine.sv
// rtl/fc_engine.sv - binary FC layer: per-chunk XNOR-popcount accumulation, then serial argmax
module fc_engine
    import fc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fc_engine_if.slave  bus
);
    fc_state_e          state_q;
    logic [5:0]         chunk_cnt_q;
    logic [3:0]         idx_q;
    logic [SCORE_W-1:0] best_val_q;
    logic [3:0]         best_idx_q;
    logic [SCORE_W-1:0] acc_q    [N_CLASSES];
    logic [SCORE_W-1:0] scores_q [N_CLASSES];
    logic [3:0]         class_q;
    logic               done_q;

    logic [CHUNK_W-1:0] fmap_chunk;
    logic [CHUNK_W-1:0] w_chunk [N_CLASSES];
    logic [4:0]         pc      [N_CLASSES];
    logic [SCORE_W-1:0] best_val_d;
    logic [3:0]         best_idx_d;

    // Operands are selected straight from the held input arrays each cycle.
    always_comb begin
        fmap_chunk = '0;
        for (int b = 0; b < CHUNK_W; b++) begin
            fmap_chunk[b] = bus.in_fmap[{chunk_cnt_q, 4'(b)}];
        end
        for (int n = 0; n < N_CLASSES; n++) begin
            w_chunk[n] = '0;
            for (int b = 0; b < CHUNK_W; b++) begin
                w_chunk[n][b] = bus.weights[14'(n * IN_W) + {4'd0, chunk_cnt_q, 4'(b)}];
            end
        end
    end

    for (genvar n = 0; n < N_CLASSES; n++) begin : g_pc
        xnor_popcount16 u_pc (
            .a_i   (fmap_chunk),
            .b_i   (w_chunk[n]),
            .cnt_o (pc[n])
        );
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (acc_q[idx_q] > best_val_q) begin
            best_val_d = acc_q[idx_q];
            best_idx_d = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chunk_cnt_q <= '0;
            idx_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            class_q     <= '0;
            done_q      <= 1'b0;
            for (int n = 0; n < N_CLASSES; n++) begin
                acc_q[n]    <= '0;
                scores_q[n] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // A start seen in the done cycle is accepted for back-to-back runs.
                    if (bus.begin_fc) begin
                        state_q     <= ACCUM;
                        chunk_cnt_q <= '0;
                        for (int n = 0; n < N_CLASSES; n++) begin
                            acc_q[n] <= SCORE_W'(bus.offset[n]);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCUM: begin
                    for (int n = 0; n < N_CLASSES; n++) begin
                        acc_q[n] <= acc_q[n] + SCORE_W'(pc[n]);
                    end
                    chunk_cnt_q <= chunk_cnt_q + 6'd1;
                    if (chunk_cnt_q == 6'(N_CHUNKS - 1)) begin
                        state_q    <= ARGMAX;
                        idx_q      <= '0;
                        best_val_q <= '0;
                        best_idx_q <= '0;
                    end
                end
                ARGMAX: begin
                    best_val_q <= best_val_d;
                    best_idx_q <= best_idx_d;
                    idx_q      <= idx_q + 4'd1;
                    if (idx_q == 4'(N_CLASSES - 1)) begin
                        state_q  <= DONE;
                        class_q  <= best_idx_d;
                        done_q   <= 1'b1;
                        scores_q <= acc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done_fc   = done_q;
    assign bus.class_out = class_q;
    for (genvar n = 0; n < N_CLASSES; n++) begin : g_out
        assign bus.scores[n] = scores_q[n];
    end
endmodule

// File: tb/tb_fc_engine.sv
// tb/tb_fc_engine.sv - directed self-checking bench for fc_engine
module tb_fc_engine;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [959:0] rnd_vec;

    fc_engine_if bus ();

    fc_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // neuron 3 weights all ones, fmap all ones, zero offsets
    task automatic setup_a();
        for (int i = 0; i < 960; i++) bus.in_fmap[i] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            bus.offset[n] = 9'd0;
            for (int i = 0; i < 960; i++) bus.weights[n*960 + i] = (n == 3);
        end
    endtask

    // neuron 7 matches random fmap, others are its complement, offset[0]=511
    task automatic setup_b();
        for (int i = 0; i < 960; i++) bus.in_fmap[i] = rnd_vec[i];
        for (int n = 0; n < 10; n++) begin
            bus.offset[n] = (n == 0) ? 9'd511 : 9'd0;
            for (int i = 0; i < 960; i++) bus.weights[n*960 + i] = (n == 7) ? rnd_vec[i] : ~rnd_vec[i];
        end
    endtask

    // every neuron matches fmap exactly, offset 5 everywhere
    task automatic setup_c();
        for (int i = 0; i < 960; i++) bus.in_fmap[i] = rnd_vec[i];
        for (int n = 0; n < 10; n++) begin
            bus.offset[n] = 9'd5;
            for (int i = 0; i < 960; i++) bus.weights[n*960 + i] = rnd_vec[i];
        end
    endtask

    task automatic start_and_wait(input string tag);
        int n;
        bus.begin_fc = 1'b1;
        step();
        bus.begin_fc = 1'b0;
        n = 1;
        while (bus.done_fc !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 71);
    endtask

    task automatic check_scores(input string tag, input int win, input int win_val,
                                input int other_val, input int sc0);
        chk({tag, "_class"}, 32'(bus.class_out), win);
        for (int n = 0; n < 10; n++) begin
            int e;
            e = (n == win) ? win_val : ((n == 0) ? sc0 : other_val);
            chk($sformatf("%s_score%0d", tag, n), 32'(bus.scores[n]), e);
        end
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 960; i++) rnd_vec[i] = 1'($urandom);
        bus.begin_fc = 1'b0;
        setup_a();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        chk("rst_done", 32'(bus.done_fc), 0);
        chk("rst_class", 32'(bus.class_out), 0);
        chk("rst_score3", 32'(bus.scores[3]), 0);

        setup_a();
        start_and_wait("one_hot");
        check_scores("one_hot", 3, 960, 0, 0);
        step();
        chk("done_one_cycle", 32'(bus.done_fc), 0);

        setup_b();
        start_and_wait("match7");
        check_scores("match7", 7, 960, 0, 511);
        step();

        setup_c();
        start_and_wait("tie");
        check_scores("tie", 0, 965, 965, 965);
        step();

        // reset 30 edges into accumulation
        setup_a();
        bus.begin_fc = 1'b1;
        step();
        bus.begin_fc = 1'b0;
        repeat (30) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_done", 32'(bus.done_fc), 0);
        chk("midrst_class", 32'(bus.class_out), 0);
        chk("midrst_score0", 32'(bus.scores[0]), 0);
        dones = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (bus.done_fc === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        start_and_wait("after_rst");
        check_scores("after_rst", 3, 960, 0, 0);
        step();

        // stray starts during accumulation and argmax
        setup_b();
        bus.begin_fc = 1'b1;
        step();
        dones = 0;
        for (int k = 1; k <= 150; k++) begin
            bus.begin_fc = (k == 10 || k == 65);
            step();
            if (bus.done_fc === 1'b1) dones++;
        end
        bus.begin_fc = 1'b0;
        chk("ignore_begin_dones", dones, 1);
        chk("ignore_begin_class", 32'(bus.class_out), 7);

        // back-to-back: new start issued in the done cycle
        setup_a();
        start_and_wait("b2b_first");
        chk("b2b_first_class", 32'(bus.class_out), 3);
        setup_b();
        bus.begin_fc = 1'b1;
        step();
        bus.begin_fc = 1'b0;
        chk("b2b_hold_class", 32'(bus.class_out), 3);
        chk("b2b_hold_score3", 32'(bus.scores[3]), 960);
        dones = 1;
        while (bus.done_fc !== 1'b1 && dones < 200) begin
            step();
            dones++;
        end
        chk("b2b_second_latency", dones, 71);
        check_scores("b2b_second", 7, 960, 0, 511);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
